uart_pattern_writer: RTL and testbench

UART_PATTERN_WRITER -- requirements
Module: uart_pattern_writer

---
 rtl/uart_pattern_writer.sv | 200 ++++++++++++++++++++
 tb/tb_uart_pattern_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_pattern_writer.sv
// UART 8N1 receiver that loads 5-bit LED patterns into an external RAM and
// commits (0x80) or aborts (0x81) the buffered pattern.
module uart_pattern_writer #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD        = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic       mem_we,
    output logic [4:0] mem_waddr,
    output logic [4:0] mem_wdata,
    output logic [4:0] last_idx,
    output logic       commit,
    output logic       overflow,
    output logic       frame_err
);

    localparam int CPB  = CLK_FREQ_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TW   = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [TW-1:0] CPB_LAST  = TW'(CPB - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic          sync1_r, sync2_r;
    state_t        state_r, state_n;
    logic [TW-1:0] timer_r, timer_n;
    logic [2:0]    bit_cnt_r, bit_cnt_n;
    logic [7:0]    shift_r, shift_n;
    logic [5:0]    wptr_r;
    logic          byte_done_s, stop_ok_s;
    logic          wr_s, cmt_s, clr_ptr_s, set_ov_s, set_fe_s, clr_flags_s;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rxd;
            sync2_r <= sync1_r;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= S_IDLE;
            timer_r   <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_n;
            timer_r   <= timer_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
        end
    end

    // Receiver next-state: start bit checked mid-bit, then every CPB clocks.
    always_comb begin
        state_n     = state_r;
        timer_n     = timer_r;
        bit_cnt_n   = bit_cnt_r;
        shift_n     = shift_r;
        byte_done_s = 1'b0;
        stop_ok_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                timer_n   = '0;
                bit_cnt_n = 3'd0;
                if (!sync2_r) begin
                    state_n = S_START;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                if (timer_r == HALF_LAST) begin
                    timer_n = '0;
                    if (!sync2_r) begin
                        state_n = S_DATA;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    timer_n = timer_r + T_ONE;
                end
            end
            S_DATA: begin
                if (timer_r == CPB_LAST) begin
                    timer_n = '0;
                    shift_n = {sync2_r, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_n = 3'd0;
                        state_n   = S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt_r + 3'd1;
                    end
                end else begin
                    timer_n = timer_r + T_ONE;
                end
            end
            S_STOP: begin
                if (timer_r == CPB_LAST) begin
                    timer_n     = '0;
                    byte_done_s = 1'b1;
                    stop_ok_s   = sync2_r;
                    state_n     = S_IDLE;
                end else begin
                    timer_n = timer_r + T_ONE;
                end
            end
            default: begin
                state_n   = S_IDLE;
                timer_n   = '0;
                bit_cnt_n = 3'd0;
            end
        endcase
    end

    // Byte decode: data write, commit, abort or bad-byte flagging.
    always_comb begin
        wr_s        = 1'b0;
        cmt_s       = 1'b0;
        clr_ptr_s   = 1'b0;
        set_ov_s    = 1'b0;
        set_fe_s    = 1'b0;
        clr_flags_s = 1'b0;
        if (byte_done_s && !stop_ok_s) begin
            set_fe_s = 1'b1;
        end else if (byte_done_s) begin
            if (shift_r[7:5] == 3'b000) begin
                if (!wptr_r[5]) begin
                    wr_s = 1'b1;
                end else begin
                    set_ov_s = 1'b1;
                end
            end else if (shift_r == 8'h80) begin
                cmt_s       = (wptr_r != 6'd0);
                clr_ptr_s   = 1'b1;
                clr_flags_s = 1'b1;
            end else if (shift_r == 8'h81) begin
                clr_ptr_s   = 1'b1;
                clr_flags_s = 1'b1;
            end else begin
                set_fe_s = 1'b1;
            end
        end else begin
            wr_s = 1'b0;
        end
    end

    // Registered outputs and write pointer; flag clear beats flag set.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_r    <= 6'd0;
            mem_we    <= 1'b0;
            mem_waddr <= 5'd0;
            mem_wdata <= 5'd0;
            last_idx  <= 5'd0;
            commit    <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            mem_we <= wr_s;
            commit <= cmt_s;
            if (wr_s) begin
                mem_waddr <= wptr_r[4:0];
                mem_wdata <= shift_r[4:0];
                wptr_r    <= wptr_r + 6'd1;
            end else if (clr_ptr_s) begin
                wptr_r <= 6'd0;
            end else begin
                wptr_r <= wptr_r;
            end
            if (cmt_s) begin
                last_idx <= 5'(wptr_r - 6'd1);
            end else begin
                last_idx <= last_idx;
            end
            if (clr_flags_s) begin
                overflow  <= 1'b0;
                frame_err <= 1'b0;
            end else begin
                overflow  <= overflow | set_ov_s;
                frame_err <= frame_err | set_fe_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_pattern_writer.sv
// Randomized scoreboard bench for uart_pattern_writer (CPB = 10).
module tb_uart_pattern_writer;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic       mem_we, commit, overflow, frame_err;
    logic [4:0] mem_waddr, mem_wdata, last_idx;

    uart_pattern_writer #(.CLK_FREQ_HZ(1000000), .BAUD(100000)) dut (
        .clk(clk), .resetn(resetn), .rxd(rxd),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .last_idx(last_idx), .commit(commit),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_commit;
        int a;
        int d;
    } ev_t;

    ev_t exp_q[$];
    int  m_wptr, m_ov, m_fe, m_li, m_wa, m_wd;
    int  n_chk = 0;
    int  n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_wptr = 0; m_ov = 0; m_fe = 0; m_li = 0; m_wa = 0; m_wd = 0;
    endtask

    // Reference behaviour of one received frame.
    task automatic model_byte(input int b, input bit stop_ok);
        ev_t e;
        if (!stop_ok) begin
            m_fe = 1;
        end else if (b < 32) begin
            if (m_wptr < 32) begin
                e.is_commit = 1'b0; e.a = m_wptr; e.d = b;
                exp_q.push_back(e);
                m_wa = m_wptr; m_wd = b; m_wptr++;
            end else begin
                m_ov = 1;
            end
        end else if (b == 128) begin
            if (m_wptr > 0) begin
                m_li = m_wptr - 1;
                e.is_commit = 1'b1; e.a = m_li; e.d = 0;
                exp_q.push_back(e);
            end
            m_wptr = 0; m_ov = 0; m_fe = 0;
        end else if (b == 129) begin
            m_wptr = 0; m_ov = 0; m_fe = 0;
        end else begin
            m_fe = 1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
        model_byte(int'(b), stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_state();
        @(negedge clk);
        chk("overflow", overflow, m_ov);
        chk("frame_err", frame_err, m_fe);
        chk("last_idx", last_idx, m_li);
        chk("mem_waddr_hold", mem_waddr, m_wa);
        chk("mem_wdata_hold", mem_wdata, m_wd);
    endtask

    initial begin
        int r, v;
        logic stop_bit;
        model_reset();

        // Monitor: every strobe must match the head of the expected queue.
        fork
            forever begin
                ev_t e;
                @(negedge clk);
                if (mem_we === 1'b1) begin
                    if (exp_q.size() == 0 || exp_q[0].is_commit) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_write: addr %0d data %0d, no write expected", mem_waddr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", mem_waddr, e.a);
                        chk("write_data", mem_wdata, e.d);
                    end
                end
                if (commit === 1'b1) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_commit) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_commit: last_idx %0d, no commit expected", last_idx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_last_idx", last_idx, e.a);
                    end
                end
            end
        join_none

        repeat (4) @(negedge clk);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_commit", commit, 0);
        check_state();
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Basic pattern and commit.
        send_frame(8'h01, 1'b1, 3);
        send_frame(8'h02, 1'b1, 3);
        send_frame(8'h04, 1'b1, 3);
        send_frame(8'h80, 1'b1, 3);
        check_state();

        // Fill beyond capacity.
        for (int i = 0; i < 33; i++) send_frame(8'h1F, 1'b1, 2);
        check_state();
        send_frame(8'h80, 1'b1, 3);
        check_state();

        // Bad stop bit, then abort, then empty commit.
        send_frame(8'h05, 1'b0, 20);
        check_state();
        send_frame(8'h81, 1'b1, 3);
        check_state();
        send_frame(8'h80, 1'b1, 3);
        check_state();

        // Short glitch on the line.
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        check_state();

        // Reset in the middle of a frame.
        send_frame(8'h03, 1'b1, 3);
        rxd = 1'b0;
        repeat (CPB * 5 + 5) @(negedge clk);
        resetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        chk("rst_mid_mem_we", mem_we, 0);
        chk("rst_mid_commit", commit, 0);
        check_state();
        repeat (20) @(negedge clk);
        send_frame(8'h80, 1'b1, 3);
        check_state();

        // Empty commit keeps last_idx; unknown byte flags.
        send_frame(8'h01, 1'b1, 3);
        send_frame(8'h02, 1'b1, 3);
        send_frame(8'h80, 1'b1, 3);
        send_frame(8'h80, 1'b1, 3);
        send_frame(8'h7F, 1'b1, 3);
        check_state();

        // Back-to-back frames with no idle gap.
        send_frame(8'h0A, 1'b1, 0);
        send_frame(8'h0B, 1'b1, 0);
        send_frame(8'h80, 1'b1, 3);
        check_state();

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                v = int'($urandom_range(0, 31));
            end else if (r < 72) begin
                v = 128;
            end else if (r < 78) begin
                v = 129;
            end else begin
                v = int'($urandom_range(32, 255));
                if (v == 128 || v == 129) v = 130;
            end
            stop_bit = ($urandom_range(0, 19) != 0);
            send_frame(8'(v), stop_bit, stop_bit ? int'($urandom_range(0, 4)) : 20);
            check_state();
        end

        repeat (30) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
